// File: rtl/uart_frame_loader.sv
// uart_frame_loader
//   Byte-stream frame loader between a UART wrapper and NUM_BANKS memories.
//   Frame: A5, CMD, ADDR_H, ADDR_L, CNT, N*BYTES payload, CHK (XOR CMD..payload).
//   Replies one byte per frame: ACK 0x06 or NAK 0x15.
// Ports:
//   clk, rst            clock, async active-high reset
//   rx_byte/rx_valid    received byte strobe
//   tx_byte/tx_valid/tx_ready  reply byte handshake
//   mem_wr_en/bank/addr/data   registered one-cycle memory write port
//   busy                registered (state != IDLE)
//   frame_ok            pulse when ACK issued
//   overrun             sticky: byte arrived while a reply was pending
module uart_frame_loader #(
    parameter int INSTR_WIDTH    = 32,
    parameter int DEPTH          = 256,
    parameter int NUM_BANKS      = 2,
    parameter int BIG_ENDIAN     = 1,
    parameter int TIMEOUT_CYCLES = 50000,
    localparam int AW = $clog2(DEPTH),
    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_byte,
    input  logic                   rx_valid,
    output logic [7:0]             tx_byte,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   mem_wr_en,
    output logic [BW-1:0]          mem_wr_bank,
    output logic [AW-1:0]          mem_wr_addr,
    output logic [INSTR_WIDTH-1:0] mem_wr_data,
    output logic                   busy,
    output logic                   frame_ok,
    output logic                   overrun
);
    localparam int BYTES = INSTR_WIDTH / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int TW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [BCW-1:0] BC_LAST  = BCW'(BYTES - 1);
    localparam logic [TW-1:0]  TMO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [4:0]     NB       = 5'(NUM_BANKS);

    localparam logic [7:0] SOF = 8'hA5;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMD   = 3'd1;
    localparam logic [2:0] S_ADDRH = 3'd2;
    localparam logic [2:0] S_ADDRL = 3'd3;
    localparam logic [2:0] S_CNT   = 3'd4;
    localparam logic [2:0] S_DATA  = 3'd5;
    localparam logic [2:0] S_CHK   = 3'd6;
    localparam logic [2:0] S_RESP  = 3'd7;

    logic [2:0]             state_q, state_d;
    logic [7:0]             xor_q, xor_d;
    logic [BW-1:0]          bank_q, bank_d;
    logic                   bad_q, bad_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [8:0]             words_q, words_d;
    logic [BCW-1:0]         bcnt_q, bcnt_d;
    logic [INSTR_WIDTH-1:0] sh_q, sh_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [7:0]             tx_byte_q, tx_byte_d;
    logic                   tx_valid_q, tx_valid_d;
    logic                   frame_ok_q, frame_ok_d;
    logic                   overrun_q, overrun_d;
    logic                   busy_q;
    logic                   wr_en_q, wr_en_d;
    logic [BW-1:0]          wr_bank_q, wr_bank_d;
    logic [AW-1:0]          wr_addr_q, wr_addr_d;
    logic [INSTR_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                   in_frame;

    assign in_frame = (state_q != S_IDLE) && (state_q != S_RESP);

    always_comb begin
        state_d    = state_q;
        xor_d      = xor_q;
        bank_d     = bank_q;
        bad_d      = bad_q;
        addr_d     = addr_q;
        words_d    = words_q;
        bcnt_d     = bcnt_q;
        sh_d       = sh_q;
        tmo_d      = '0;
        tx_byte_d  = tx_byte_q;
        tx_valid_d = tx_valid_q;
        frame_ok_d = 1'b0;
        overrun_d  = overrun_q;
        wr_en_d    = 1'b0;
        wr_bank_d  = wr_bank_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        // XOR covers every byte from CMD through the last payload byte.
        if (rx_valid && (state_q inside {S_CMD, S_ADDRH, S_ADDRL, S_CNT, S_DATA}))
            xor_d = xor_q ^ rx_byte;

        case (state_q)
            S_IDLE: if (rx_valid && rx_byte == SOF) begin
                state_d = S_CMD;
                xor_d   = '0;
                bad_d   = 1'b0;
                bcnt_d  = '0;
            end
            S_CMD: if (rx_valid) begin
                if (rx_byte[7:4] != 4'h1) begin
                    state_d    = S_RESP;
                    tx_valid_d = 1'b1;
                    tx_byte_d  = NAK;
                end else begin
                    state_d = S_ADDRH;
                    bank_d  = rx_byte[BW-1:0];
                    // Out-of-range bank: consume the frame but never write.
                    bad_d   = {1'b0, rx_byte[3:0]} >= NB;
                end
            end
            S_ADDRH: if (rx_valid) begin
                // High byte lands in bits [15:8]; the cast drops bits above AW.
                addr_d  = AW'({rx_byte, 8'h00});
                state_d = S_ADDRL;
            end
            S_ADDRL: if (rx_valid) begin
                addr_d  = addr_q | AW'(rx_byte);
                state_d = S_CNT;
            end
            S_CNT: if (rx_valid) begin
                words_d = (rx_byte == 8'h00) ? 9'd256 : 9'(rx_byte);
                state_d = S_DATA;
            end
            S_DATA: if (rx_valid) begin
                if (BIG_ENDIAN != 0)
                    sh_d = (sh_q << 8) | INSTR_WIDTH'(rx_byte);
                else
                    sh_d = (sh_q >> 8) | (INSTR_WIDTH'(rx_byte) << (INSTR_WIDTH - 8));
                if (bcnt_q == BC_LAST) begin
                    bcnt_d    = '0;
                    wr_en_d   = !bad_q;
                    wr_bank_d = bank_q;
                    wr_addr_d = addr_q;
                    wr_data_d = sh_d;
                    addr_d    = addr_q + 1'b1;   // wraps modulo DEPTH
                    words_d   = words_q - 9'd1;
                    if (words_q == 9'd1) state_d = S_CHK;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            S_CHK: if (rx_valid) begin
                state_d    = S_RESP;
                tx_valid_d = 1'b1;
                if (rx_byte == xor_q && !bad_q) begin
                    tx_byte_d  = ACK;
                    frame_ok_d = 1'b1;
                end else begin
                    tx_byte_d  = NAK;
                end
            end
            default: begin // S_RESP
                if (rx_valid) overrun_d = 1'b1;
                if (tx_valid_q && tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
        endcase

        // Idle-gap timeout; only counts on cycles without a byte, so it never
        // collides with a byte-driven transition above.
        if (in_frame && TIMEOUT_CYCLES > 0 && !rx_valid) begin
            tmo_d = tmo_q + 1'b1;
            if (tmo_q == TMO_LAST) begin
                state_d    = S_RESP;
                tx_valid_d = 1'b1;
                tx_byte_d  = NAK;
                tmo_d      = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            xor_q      <= '0;
            bank_q     <= '0;
            bad_q      <= 1'b0;
            addr_q     <= '0;
            words_q    <= '0;
            bcnt_q     <= '0;
            sh_q       <= '0;
            tmo_q      <= '0;
            tx_byte_q  <= '0;
            tx_valid_q <= 1'b0;
            frame_ok_q <= 1'b0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_bank_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            xor_q      <= xor_d;
            bank_q     <= bank_d;
            bad_q      <= bad_d;
            addr_q     <= addr_d;
            words_q    <= words_d;
            bcnt_q     <= bcnt_d;
            sh_q       <= sh_d;
            tmo_q      <= tmo_d;
            tx_byte_q  <= tx_byte_d;
            tx_valid_q <= tx_valid_d;
            frame_ok_q <= frame_ok_d;
            overrun_q  <= overrun_d;
            busy_q     <= (state_d != S_IDLE);
            wr_en_q    <= wr_en_d;
            wr_bank_q  <= wr_bank_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign tx_byte     = tx_byte_q;
    assign tx_valid    = tx_valid_q;
    assign frame_ok    = frame_ok_q;
    assign overrun     = overrun_q;
    assign busy        = busy_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_wr_bank = wr_bank_q;
    assign mem_wr_addr = wr_addr_q;
    assign mem_wr_data = wr_data_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Scoreboard bench for uart_frame_loader: stimulus pushes expected writes and
// replies into queues; a negedge monitor pops and compares them.
module tb_uart_frame_loader;
    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic        mem_wr_en;
    logic [0:0]  mem_wr_bank;
    logic [7:0]  mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        busy;
    logic        frame_ok;
    logic        overrun;

    uart_frame_loader #(
        .INSTR_WIDTH(32), .DEPTH(256), .NUM_BANKS(2),
        .BIG_ENDIAN(1), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .rx_byte(rx_byte), .rx_valid(rx_valid),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .mem_wr_en(mem_wr_en), .mem_wr_bank(mem_wr_bank),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .busy(busy), .frame_ok(frame_ok), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:0]  bank;
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t        wq[$];
    logic [7:0] rq[$];
    logic [7:0] frm[$];
    int         n_tot  = 0;
    int         n_pass = 0;
    int         fok    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: compares every DUT write and reply handshake against the queues.
    wr_t e;
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_wr_en) begin
                if (wq.size() == 0) check("wr_unexpected", 64'(mem_wr_addr), 64'hFFFF);
                else begin
                    e = wq.pop_front();
                    check("wr_bank", 64'(mem_wr_bank), 64'(e.bank));
                    check("wr_addr", 64'(mem_wr_addr), 64'(e.addr));
                    check("wr_data", 64'(mem_wr_data), 64'(e.data));
                end
            end
            if (tx_valid && tx_ready) begin
                if (rq.size() == 0) check("reply_unexpected", 64'(tx_byte), 64'hFFFF);
                else check("reply", 64'(tx_byte), 64'(rq.pop_front()));
            end
            if (frame_ok) fok++;
        end
    end

    task automatic send(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame();
        foreach (frm[i]) send(frm[i]);
    endtask

    task automatic push_wr(input logic [0:0] b, input logic [7:0] a, input logic [31:0] d);
        wr_t w;
        w.bank = b; w.addr = a; w.data = d;
        wq.push_back(w);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && (wq.size() != 0 || rq.size() != 0); i++) begin
            @(posedge clk); #1;
        end
        check({"drain_", name}, 64'(wq.size() + rq.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_tx_valid", 64'(tx_valid), 0);
        check("rst_tx_byte", 64'(tx_byte), 0);
        check("rst_wr_en", 64'(mem_wr_en), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_frame_ok", 64'(frame_ok), 0);
        check("rst_overrun", 64'(overrun), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: good single-word frame
        fok = 0;
        frm = '{8'hA5, 8'h10, 8'h00, 8'h10, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23};
        push_wr(1'b0, 8'h10, 32'hDEADBEEF); rq.push_back(8'h06);
        send_frame(); drain("t1");
        check("t1_frame_ok", 64'(fok), 1);

        // 2: bad checksum, write still committed
        fok = 0;
        frm = '{8'hA5, 8'h10, 8'h00, 8'h10, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h24};
        push_wr(1'b0, 8'h10, 32'hDEADBEEF); rq.push_back(8'h15);
        send_frame(); drain("t2");
        check("t2_frame_ok", 64'(fok), 0);

        // 3: address wrap across DEPTH, bank 1
        fok = 0;
        frm = '{8'hA5, 8'h11, 8'h00, 8'hFF, 8'h03,
                8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
                8'h33, 8'h33, 8'h33, 8'h33, 8'hED};
        push_wr(1'b1, 8'hFF, 32'h11111111);
        push_wr(1'b1, 8'h00, 32'h22222222);
        push_wr(1'b1, 8'h01, 32'h33333333);
        rq.push_back(8'h06);
        send_frame(); drain("t3");
        check("t3_frame_ok", 64'(fok), 1);

        // 4: bank 3 out of range, valid checksum -> no writes, NAK
        fok = 0;
        frm = '{8'hA5, 8'h13, 8'h00, 8'h00, 8'h02,
                8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h19};
        rq.push_back(8'h15);
        send_frame(); drain("t4");
        check("t4_frame_ok", 64'(fok), 0);

        // 5: illegal op -> immediate NAK; trailing bytes ignored in IDLE
        fok = 0;
        frm = '{8'hA5, 8'h20};
        rq.push_back(8'h15);
        send_frame();
        repeat (4) @(posedge clk);
        #1;
        frm = '{8'h00, 8'h10, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23};
        send_frame();
        repeat (10) @(posedge clk);
        #1;
        drain("t5");
        check("t5_frame_ok", 64'(fok), 0);
        check("t5_overrun", 64'(overrun), 0);
        check("t5_busy_idle", 64'(busy), 0);

        // 5b: recovery frame after the ignored bytes
        fok = 0;
        frm = '{8'hA5, 8'h10, 8'h00, 8'h20, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h35};
        push_wr(1'b0, 8'h20, 32'h01020304); rq.push_back(8'h06);
        send_frame(); drain("t5b");
        check("t5b_frame_ok", 64'(fok), 1);

        // 6: timeout after two payload bytes, then overrun during RESP
        fok = 0;
        tx_ready = 1'b0;
        frm = '{8'hA5, 8'h10, 8'h00, 8'h40, 8'h01, 8'hDE, 8'hAD};
        rq.push_back(8'h15);
        send_frame();
        repeat (TMO - 2) @(posedge clk);
        #1;
        check("t6_no_early_timeout", 64'(tx_valid), 0);
        repeat (3) @(posedge clk);
        #1;
        check("t6_timeout_pending", 64'(tx_valid), 1);
        check("t6_timeout_byte", 64'(tx_byte), 64'h15);
        check("t6_overrun_before", 64'(overrun), 0);
        send(8'h55);
        check("t6_overrun", 64'(overrun), 1);
        check("t6_hold_valid", 64'(tx_valid), 1);
        tx_ready = 1'b1;
        drain("t6");
        check("t6_frame_ok", 64'(fok), 0);
        check("t6_overrun_sticky", 64'(overrun), 1);

        // 7: reset mid-DATA clears everything and produces no reply
        frm = '{8'hA5, 8'h10, 8'h00, 8'h50, 8'h01, 8'hDE, 8'hAD};
        send_frame();
        rst = 1'b1;
        #1;
        check("t7_tx_valid", 64'(tx_valid), 0);
        check("t7_wr_en", 64'(mem_wr_en), 0);
        check("t7_wr_data", 64'(mem_wr_data), 0);
        check("t7_busy", 64'(busy), 0);
        check("t7_overrun", 64'(overrun), 0);
        check("t7_frame_ok", 64'(frame_ok), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (TMO + 20) @(posedge clk);
        #1;
        check("t7_no_reply", 64'(tx_valid), 0);
        check("t7_queues_empty", 64'(wq.size() + rq.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_frame_loader.md
# uart_frame_loader

Byte-stream frame loader that sits between the UART receiver/transmitter and up to `NUM_BANKS` instruction/data memories of the vector processing unit. It generalises the start/stop loader in four ways: configurable word width, endianness, bank count and depth; addressed bursts; checksum validation; and an ACK/NAK reply to the host. It has no UART inside. It consumes `rx_byte`/`rx_valid` from the UART wrapper, drives a registered memory write port, and returns one reply byte per frame via a valid/ready TX handshake.

## Interface
- `INSTR_WIDTH`, 32: memory word width; multiple of 8, range 8..64. `BYTES = INSTR_WIDTH/8`.
- `DEPTH`, 256: words per bank; power of 2, range 2..65536. `AW = $clog2(DEPTH)`.
- `NUM_BANKS`, 2: number of target memories, range 1..16. `BW = max(1,$clog2(NUM_BANKS))`.
- `BIG_ENDIAN`, 1: 1 means the first payload byte is the word MSB; 0 means it is the LSB.
- `TIMEOUT_CYCLES`, 50000: maximum idle gap between bytes inside a frame; 0 disables the timeout.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `rx_byte` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe, `rx_byte` valid.
- `tx_byte` out 8: reply byte.
- `tx_valid` out 1: reply pending.
- `tx_ready` in 1: UART TX accepts the byte.
- `mem_wr_en` out 1: one-cycle write strobe.
- `mem_wr_bank` out BW: target bank index.
- `mem_wr_addr` out AW: word address.
- `mem_wr_data` out INSTR_WIDTH: assembled word.
- `busy` out 1: FSM not in IDLE.
- `frame_ok` out 1: one-cycle pulse when an ACK is issued.
- `overrun` out 1: sticky; a byte arrived during RESP. Cleared only by `rst`.

## Operation
- Frame format: `0xA5` (SOF), CMD, ADDR_H, ADDR_L, CNT, payload of N×BYTES bytes, CHK.
- CMD[7:4] is the op; only `0x1` (write) is legal. CMD[3:0] is the bank. The address is `{ADDR_H,ADDR_L}` truncated to AW bits. N = CNT, with CNT=0 meaning 256.
- CHK equals the XOR of CMD through the last payload byte. SOF is excluded.
- States: IDLE, CMD, ADDR_H, ADDR_L, CNT, DATA, CHK, RESP.
- IDLE: every byte except `0xA5` is discarded. `0xA5` moves to CMD.
- CMD: if op ≠ 0x1, go to RESP with NAK. Otherwise latch the bank and go to ADDR_H. If bank ≥ NUM_BANKS, set the internal `bad` flag; the frame is still consumed but all writes are suppressed.
- ADDR_H → ADDR_L → CNT → DATA: each transition takes exactly one accepted byte. The running XOR updates on every byte from CMD onward.
- DATA: bytes accumulate into a shift register in the order set by `BIG_ENDIAN`. A byte counter runs 0..BYTES−1. On the BYTES-th byte, a write of the assembled word to (bank, addr) is issued unless `bad` is set. After each word, addr increments and wraps modulo DEPTH. After word N, go to CHK.
- CHK: if the received byte equals the running XOR and `bad`=0, reply ACK `0x06` and pulse `frame_ok`. Otherwise reply NAK `0x15`.
- Writes are committed as they arrive; the checksum does not roll them back. On NAK, the host resends the frame.
- RESP: `tx_valid`=1 with `tx_byte` held until `tx_ready`=1, then go to IDLE. Any `rx_valid` in RESP drops the byte and sets `overrun`.
- Timeout: in CMD..CHK, a counter resets on each `rx_valid` and increments otherwise. Reaching `TIMEOUT_CYCLES` aborts to RESP with NAK. Partial words are not written.
- `0xA5` inside a frame is ordinary data; there is no resync.

## Timing
- Reset values: all outputs 0, state IDLE, XOR 0, addr 0, `bad` 0, `overrun` 0. Reset mid-frame abandons the frame immediately, with no write and no reply.
- One byte is accepted per `rx_valid` cycle; back-to-back strobes must be handled.
- `mem_wr_en`/bank/addr/data are registered and valid in the cycle after the `rx_valid` carrying a word's final byte. Strobe width is exactly one cycle.
- `tx_valid` and `frame_ok` rise in the cycle after the `rx_valid` carrying CHK, or after the cycle the timeout or bad op is detected.
- `tx_valid` falls in the cycle after the `tx_valid && tx_ready` handshake. If `tx_ready` is already high, the handshake completes in the first RESP cycle.
- `busy` is the registered value of (state ≠ IDLE).

## Test plan
- Bank 0, addr 0x0010, CNT=1, word `DE AD BE EF`, CHK=0x23, BIG_ENDIAN=1 → one write, bank 0, addr 0x10, data 0xDEADBEEF; reply 0x06; `frame_ok` pulses once.
- Same frame with CHK=0x24 → write still occurs; reply 0x15; no `frame_ok`.
- Addr 0x00FF, CNT=3, DEPTH=256 → writes at 0xFF, 0x00, 0x01 in order; ACK.
- CMD=0x13 with NUM_BANKS=2, CNT=2, correct CHK → no `mem_wr_en`; NAK after CHK.
- CMD=0x20 → NAK immediately; the following bytes are ignored until the next `0xA5`.
- Stop after 2 payload bytes, idle for TIMEOUT_CYCLES → NAK and no write. A byte sent with `tx_ready`=0 during RESP → `overrun`=1. Assert `rst` mid-DATA → all outputs 0 and no reply.
